dm_cache: RTL
=============

# dm_cache

Parametrised direct-mapped, write-through cache controller between the processor's data port and the RAM block. It is the next generation of the existing single-line cache. It adds configurable line count, a registered request/acknowledge handshake to a variable-latency RAM, a one-cycle flush, and saturating hit/miss statistics counters. All RAM-side signals are unidirectional, so the block needs no bidirectional buffers.

## Interface
- d_width, 4, data bus width
- a_width, 8, address width
- idx_width, 3, index bits; lines = 2^idx_width; tag width = a_width − idx_width (must be ≥1)
- cnt_width, 8, statistics counter width

Ports:
- clk  in  1  clock, all state changes on rising edge
- clr  in  1  reset, asynchronous, active-low
- addr  in  a_width  request address
- data_in  in  d_width  write data
- rw  in  1  1 = read, 0 = write
- ce  in  1  request strobe; sampled only when busy=0
- flush  in  1  invalidate all lines
- data_out  out  d_width  read data, valid while odv=1
- odv  out  1  one-cycle read-data-valid pulse
- busy  out  1  controller cannot accept a request
- ram_addr  out  a_width  RAM address
- ram_wdata  out  d_width  RAM write data
- ram_rw  out  1  RAM direction (1 = read)
- ram_ce  out  1  RAM request, held until ram_ack
- ram_rdata  in  d_width  RAM read data, valid with ram_ack
- ram_ack  in  1  RAM completion, sampled only while ram_ce=1
- hit_cnt  out  cnt_width  read hits, saturating
- miss_cnt  out  cnt_width  read misses, saturating

## Operation
- Per line: valid bit, tag, d_width data word. Index = addr[idx_width-1:0]; tag = addr[a_width-1:idx_width].
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE, ce=1, rw=1, hit (valid and tags match): data_out ← line data, odv=1 next cycle, hit_cnt+1, stay IDLE.
- IDLE, ce=1, rw=1, miss: latch addr, go to RD_MISS, miss_cnt+1.
- RD_MISS: ram_ce=1, ram_rw=1. On ram_ack:
  - fill line (valid=1, tag, ram_rdata).
  - data_out ← ram_rdata, odv=1 next cycle, go to IDLE.
- IDLE, ce=1, rw=0: go to WR_THRU.
  - Latch addr and data_in.
  - If hit, update line data in the same edge.
  - Write miss does not allocate. Counters are unchanged on any write.
- WR_THRU: ram_ce=1, ram_rw=0, ram_wdata = latched data. On ram_ack, go to IDLE.
- busy = (state ≠ IDLE). ce while busy is ignored; no queuing.
- flush in IDLE with no ce: all valid bits clear at the next edge.
- flush while busy, or coincident with ce: held pending, then applied on the edge that returns to IDLE. A fill in that same edge is also invalidated.
- Counters saturate at 2^cnt_width − 1 and are cleared only by reset.

## Timing
- Reset (clr=0, asynchronous): state IDLE, all valid=0, all outputs 0 (data_out, odv, busy, ram_*, counters), pending flush cleared.
- Reset mid-miss: ram_ce drops immediately and the fill is abandoned.
- Read hit latency: 1 cycle from accept edge to odv.
- Miss or write: busy and ram_ce rise 1 cycle after accept.
  - ram_ack may be asserted in that first ram_ce cycle (minimum 1-cycle RAM).
  - ram_ce and busy fall 1 cycle after ack is sampled.
  - Read-miss odv coincides with busy falling.
- A back-to-back request is accepted on the first cycle busy=0.
- ram_addr, ram_rw and ram_wdata are stable for the whole time ram_ce=1.

## Structure
- Package cache_pkg:
  - FSM state encoding.
  - Derived constants: tag width, line count.
  - Reset/idle values.
- Sub-module cache_tag_array holds valid/tag/data storage. It provides:
  - Combinational lookup with a hit output.
  - Write and fill ports.
  - Single-cycle flush.
- FSM, handshake and counters stay in dm_cache.

## Test plan
- Reset: clr=0 mid-RD_MISS → ram_ce, busy, odv, counters all 0 immediately; read of 0x12 after reset misses.
- Cold read 0x25, RAM returns 0xA after 3 cycles → miss_cnt=1, odv with 0xA; re-read 0x25 → hit, odv 1 cycle after ce, hit_cnt=1, ram_ce stays 0.
- Conflict: read 0x05 then 0x0D (same index, idx_width=3) → both miss; read 0x05 again misses (evicted).
- Write 0x7 to cached 0x25 → ram_ce with ram_rw=0, ram_wdata=0x7; subsequent read 0x25 hits with 0x7; write to uncached 0x33 then read 0x33 → miss.
- Flush asserted during WR_THRU → line stays valid until the ack edge; read afterward misses.
- 300 hits on 0x25 with cnt_width=8 → hit_cnt saturates at 255; ce pulses while busy produce no extra RAM transactions.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and derived constants for the direct-mapped write-through cache.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2
  } state_e;

  localparam int D_WIDTH_DEF   = 4;
  localparam int A_WIDTH_DEF   = 8;
  localparam int IDX_WIDTH_DEF = 3;
  localparam int CNT_WIDTH_DEF = 8;

  localparam state_e STATE_RST  = ST_IDLE;
  localparam logic   RAM_RW_RST = 1'b0;

  function automatic int tag_width(input int a_w, input int idx_w);
    return a_w - idx_w;
  endfunction

  function automatic int line_count(input int idx_w);
    return 1 << idx_w;
  endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Valid/tag/data storage with combinational lookup, write-hit and fill ports,
// and a single-cycle flush that overrides a coincident fill.
module cache_tag_array
  import cache_pkg::*;
#(
  parameter int d_width   = D_WIDTH_DEF,
  parameter int a_width   = A_WIDTH_DEF,
  parameter int idx_width = IDX_WIDTH_DEF
) (
  input  logic                                clk,
  input  logic                                clr,
  input  logic [a_width-1:0]                  lookup_addr_i,
  output logic                                hit_o,
  output logic [d_width-1:0]                  lookup_data_o,
  input  logic                                wr_en_i,
  input  logic [idx_width-1:0]                wr_idx_i,
  input  logic [d_width-1:0]                  wr_data_i,
  input  logic                                fill_en_i,
  input  logic [idx_width-1:0]                fill_idx_i,
  input  logic [tag_width(a_width, idx_width)-1:0] fill_tag_i,
  input  logic [d_width-1:0]                  fill_data_i,
  input  logic                                flush_i
);

  localparam int TAG_W = tag_width(a_width, idx_width);
  localparam int LINES = line_count(idx_width);

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [d_width-1:0] data_q [LINES];

  logic [idx_width-1:0] lk_idx;
  logic [TAG_W-1:0]     lk_tag;

  assign lk_idx        = lookup_addr_i[idx_width-1:0];
  assign lk_tag        = lookup_addr_i[a_width-1:idx_width];
  assign hit_o         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lookup_data_o = data_q[lk_idx];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is meaningless until its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_data_i;
    end else if (wr_en_i) begin
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped write-through cache controller: request FSM, RAM handshake,
// deferred flush and saturating hit/miss counters around cache_tag_array.
module dm_cache
  import cache_pkg::*;
#(
  parameter int d_width   = D_WIDTH_DEF,
  parameter int a_width   = A_WIDTH_DEF,
  parameter int idx_width = IDX_WIDTH_DEF,
  parameter int cnt_width = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [a_width-1:0]   addr,
  input  logic [d_width-1:0]   data_in,
  input  logic                 rw,
  input  logic                 ce,
  input  logic                 flush,
  output logic [d_width-1:0]   data_out,
  output logic                 odv,
  output logic                 busy,
  output logic [a_width-1:0]   ram_addr,
  output logic [d_width-1:0]   ram_wdata,
  output logic                 ram_rw,
  output logic                 ram_ce,
  input  logic [d_width-1:0]   ram_rdata,
  input  logic                 ram_ack,
  output logic [cnt_width-1:0] hit_cnt,
  output logic [cnt_width-1:0] miss_cnt
);

  state_e               state_q;
  logic [a_width-1:0]   addr_q;
  logic [d_width-1:0]   wdata_q;
  logic [d_width-1:0]   data_out_q;
  logic                 odv_q;
  logic                 ram_ce_q;
  logic                 ram_rw_q;
  logic                 flush_pend_q;
  logic [cnt_width-1:0] hit_cnt_q;
  logic [cnt_width-1:0] miss_cnt_q;

  logic               hit;
  logic               hit_eff;
  logic               ack;
  logic               fill_en;
  logic               wr_en;
  logic               flush_now;
  logic [d_width-1:0] line_data;

  // A pending flush is applied on this IDLE edge, so lines already count as invalid.
  always_comb begin
    hit_eff   = hit && !flush_pend_q;
    ack       = ram_ce_q && ram_ack;
    fill_en   = (state_q == ST_RD_MISS) && ack;
    wr_en     = (state_q == ST_IDLE) && ce && !rw && hit_eff;
    flush_now = 1'b0;
    if (state_q == ST_IDLE) begin
      flush_now = (flush && !ce) || flush_pend_q;
    end else if (ack) begin
      flush_now = flush || flush_pend_q;
    end
  end

  cache_tag_array #(
    .d_width   (d_width),
    .a_width   (a_width),
    .idx_width (idx_width)
  ) u_tags (
    .clk           (clk),
    .clr           (clr),
    .lookup_addr_i (addr),
    .hit_o         (hit),
    .lookup_data_o (line_data),
    .wr_en_i       (wr_en),
    .wr_idx_i      (addr[idx_width-1:0]),
    .wr_data_i     (data_in),
    .fill_en_i     (fill_en),
    .fill_idx_i    (addr_q[idx_width-1:0]),
    .fill_tag_i    (addr_q[a_width-1:idx_width]),
    .fill_data_i   (ram_rdata),
    .flush_i       (flush_now)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= STATE_RST;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_out_q   <= '0;
      odv_q        <= 1'b0;
      ram_ce_q     <= 1'b0;
      ram_rw_q     <= RAM_RW_RST;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      odv_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          flush_pend_q <= ce && flush;
          if (ce) begin
            if (rw && hit_eff) begin
              data_out_q <= line_data;
              odv_q      <= 1'b1;
              if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            end else begin
              addr_q   <= addr;
              wdata_q  <= data_in;
              ram_ce_q <= 1'b1;
              ram_rw_q <= rw;
              state_q  <= rw ? ST_RD_MISS : ST_WR_THRU;
              if (rw && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
            end
          end
        end
        ST_RD_MISS, ST_WR_THRU: begin
          if (ack) begin
            ram_ce_q     <= 1'b0;
            state_q      <= ST_IDLE;
            flush_pend_q <= 1'b0;
            if (state_q == ST_RD_MISS) begin
              data_out_q <= ram_rdata;
              odv_q      <= 1'b1;
            end
          end else begin
            flush_pend_q <= flush_pend_q || flush;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign data_out  = data_out_q;
  assign odv       = odv_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_rw    = ram_rw_q;
  assign ram_ce    = ram_ce_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule
